// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the hash-engine memory port arbiter.
// Burst lengths are clamped into 1..MAX_BURST before counting.
package mem_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_LEN_W   = 5;
    localparam int MAX_BURST   = 16;
    localparam int CNT_W       = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        WAIT  = 2'd2,
        LAST  = 2'd3
    } state_t;

    // A zero-length request still moves one word.
    function automatic logic [CNT_W-1:0] eff_len(input int unsigned len);
        if (len == 0)
            return CNT_W'(1);
        else if (len > MAX_BURST)
            return CNT_W'(MAX_BURST);
        else
            return CNT_W'(len);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: one-hot choice of the first active
// request found after the previous grantee, wrapping modulo N.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  request,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  pick
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        // The previous grantee is visited last, so it only wins when alone.
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last) + k) % N);
            if (!found && request[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin burst arbiter sharing one synchronous memory port among
// NUM_REQ hash engines; one beat per cycle, one-cycle read latency.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      take,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic [NUM_REQ-1:0]        done,
    output logic                      mem_clk,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_write_data,
    input  logic [DATA_W-1:0]         mem_read_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state_reg;
    logic [NUM_REQ-1:0]  gnt_reg;
    logic                take_reg;
    logic [NUM_REQ-1:0]  rd_valid_reg;
    logic [NUM_REQ-1:0]  done_reg;
    logic                beat_valid_reg;
    logic                mem_we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]   mem_wdata_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                we_reg;
    logic [IDX_W-1:0]    last_reg;

    logic [NUM_REQ-1:0]  pick;
    logic [IDX_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0]  grant_onehot;

    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [LEN_W-1:0]    len_arr   [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign len_arr[gi]   = req_len[gi*LEN_W +: LEN_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_picker (
        .request (req),
        .last    (last_reg),
        .pick    (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick[k])
                pick_idx = IDX_W'(k);
        end
    end

    assign grant_onehot = NUM_REQ'(1) << last_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            gnt_reg        <= '0;
            take_reg       <= 1'b0;
            rd_valid_reg   <= '0;
            done_reg       <= '0;
            beat_valid_reg <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            addr_reg       <= '0;
            cnt_reg        <= '0;
            we_reg         <= 1'b0;
            last_reg       <= IDX_W'(NUM_REQ - 1);
        end else begin
            beat_valid_reg <= 1'b0;
            // Memory returns a word one cycle after its address is presented.
            rd_valid_reg   <= (beat_valid_reg && !we_reg) ? grant_onehot : '0;
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        gnt_reg   <= pick;
                        last_reg  <= pick_idx;
                        we_reg    <= req_we[pick_idx];
                        addr_reg  <= addr_arr[pick_idx];
                        cnt_reg   <= eff_len(32'(len_arr[pick_idx]));
                        take_reg  <= 1'b1;
                        state_reg <= BURST;
                    end
                end
                BURST: begin
                    mem_addr_reg   <= addr_reg;
                    mem_we_reg     <= we_reg;
                    mem_wdata_reg  <= wdata_arr[last_reg];
                    beat_valid_reg <= 1'b1;
                    addr_reg       <= addr_reg + ADDR_W'(1);
                    cnt_reg        <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        take_reg  <= 1'b0;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    mem_we_reg <= 1'b0;
                    gnt_reg    <= '0;
                    done_reg   <= grant_onehot;
                    state_reg  <= LAST;
                end
                LAST: begin
                    done_reg  <= '0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt            = gnt_reg;
    assign take           = take_reg;
    assign rd_valid       = rd_valid_reg;
    assign done           = done_reg;
    assign rd_data        = mem_read_data;
    assign mem_clk        = clk;
    assign mem_we         = mem_we_reg;
    assign mem_addr       = mem_addr_reg;
    assign mem_write_data = mem_wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single bursts checked
// cycle by cycle, plus contention and mid-burst reset sequences.
module tb_mem_port_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [3:0]   req_we;
    logic [63:0]  req_addr;
    logic [19:0]  req_len;
    logic [127:0] req_wdata;
    logic [3:0]   gnt;
    logic         take;
    logic [3:0]   rd_valid;
    logic [31:0]  rd_data;
    logic [3:0]   done;
    logic         mem_clk;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_write_data;
    logic [31:0]  mem_read_data;

    int checks   = 0;
    int failures = 0;
    int wptr [4] = '{0, 0, 0, 0};

    typedef struct {
        int          idx;
        logic        we;
        logic [15:0] addr;
        logic [4:0]  len;
        int          beats;
    } vec_t;

    vec_t tab [6];

    mem_port_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .req_wdata      (req_wdata),
        .gnt            (gnt),
        .take           (take),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .done           (done),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle latency, word tagged with its address.
    always @(posedge clk)
        mem_read_data <= 32'hC0DE0000 | {16'h0, mem_addr};

    // Writer model: each engine steps to its next word after a taken beat.
    always @(posedge clk) begin
        if (take) begin
            for (int i = 0; i < 4; i++)
                if (gnt[i]) wptr[i] <= wptr[i] + 1;
        end
    end

    always_comb begin
        req_wdata = '0;
        for (int i = 0; i < 4; i++)
            req_wdata[i*32 +: 32] = 32'hA + 32'(wptr[i]) + 32'(i * 256);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_burst(input int n, input vec_t v);
        logic [3:0]  oh;
        logic [3:0]  exp_rv;
        logic [31:0] w0;
        int          L;
        oh = 4'b0001 << v.idx;
        L  = v.beats;
        w0 = 32'hA + 32'(wptr[v.idx]) + 32'(v.idx * 256);
        req                      = oh;
        req_we                   = '0;
        req_we[v.idx]            = v.we;
        req_addr[v.idx*16 +: 16] = v.addr;
        req_len[v.idx*5 +: 5]    = v.len;
        for (int k = 1; k <= L + 3; k++) begin
            tick();
            chk($sformatf("v%0d_c%0d_gnt", n, k), 64'(gnt), 64'((k <= L + 1) ? oh : 4'b0));
            chk($sformatf("v%0d_c%0d_take", n, k), 64'(take), 64'(k <= L));
            chk($sformatf("v%0d_c%0d_done", n, k), 64'(done), 64'((k == L + 2) ? oh : 4'b0));
            exp_rv = (!v.we && k >= 3 && k <= L + 2) ? oh : 4'b0;
            chk($sformatf("v%0d_c%0d_rd_valid", n, k), 64'(rd_valid), 64'(exp_rv));
            if (exp_rv != 4'b0)
                chk($sformatf("v%0d_c%0d_rd_data", n, k), 64'(rd_data),
                    64'(32'hC0DE0000 | {16'h0, 16'(v.addr + 16'(k - 3))}));
            if (k >= 2 && k <= L + 1) begin
                chk($sformatf("v%0d_c%0d_mem_addr", n, k), 64'(mem_addr), 64'(16'(v.addr + 16'(k - 2))));
                chk($sformatf("v%0d_c%0d_mem_we", n, k), 64'(mem_we), 64'(v.we));
                if (v.we)
                    chk($sformatf("v%0d_c%0d_wdata", n, k), 64'(mem_write_data), 64'(w0 + 32'(k - 2)));
            end
            if (k == L + 2)
                chk($sformatf("v%0d_last_mem_we", n), 64'(mem_we), 64'(0));
            if (k == 1) begin
                // Fields change mid-burst; the latched burst must be unaffected.
                req      = '0;
                req_we   = ~req_we;
                req_addr = '1;
                req_len  = '0;
            end
        end
        $display("burst %0d: req=%0d we=%0d addr=0x%04h len=%0d beats=%0d failures_so_far=%0d",
                 n, v.idx, v.we, v.addr, v.len, L, failures);
    endtask

    initial begin
        int          ng;
        int          gidx [5];
        int          gcyc [5];
        logic [3:0]  prev;

        tab[0] = '{1, 1'b0, 16'h0010, 5'd3,  3};
        tab[1] = '{0, 1'b1, 16'h0020, 5'd2,  2};
        tab[2] = '{2, 1'b0, 16'hFFFE, 5'd20, 16};
        tab[3] = '{3, 1'b1, 16'h0100, 5'd0,  1};
        tab[4] = '{3, 1'b0, 16'h0200, 5'd16, 16};
        tab[5] = '{1, 1'b1, 16'hFFFF, 5'd17, 16};

        reset    = 1'b1;
        req      = '0;
        req_we   = '0;
        req_addr = '0;
        req_len  = '0;
        tick();
        tick();
        chk("rst_gnt", 64'(gnt), 64'(0));
        chk("rst_take", 64'(take), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_rd_valid", 64'(rd_valid), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(mem_write_data), 64'(0));
        chk("mem_clk_follows_clk", 64'(mem_clk), 64'(clk));
        reset = 1'b0;
        tick();
        chk("idle_gnt", 64'(gnt), 64'(0));

        for (int n = 0; n < 6; n++)
            run_burst(n, tab[n]);

        // Contention from a fresh reset: order must start at requester 0.
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        req      = 4'b1111;
        req_we   = 4'b0000;
        req_len  = '0;
        req_addr = 64'h0300_0200_0100_0000;
        ng   = 0;
        prev = '0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            chk($sformatf("cont_c%0d_onehot", c), 64'($countones(gnt) <= 1), 64'(1));
            if (gnt != 4'b0 && prev == 4'b0 && ng < 5) begin
                gidx[ng] = 0;
                for (int i = 0; i < 4; i++)
                    if (gnt[i]) gidx[ng] = i;
                gcyc[ng] = c;
                ng++;
            end
            prev = gnt;
        end
        req = '0;
        chk("cont_grant_count", 64'(ng), 64'(5));
        for (int i = 0; i < ng; i++) begin
            chk($sformatf("cont_grant%0d_idx", i), 64'(gidx[i]), 64'(i % 4));
            if (i > 0)
                chk($sformatf("cont_grant%0d_spacing", i), 64'(gcyc[i] - gcyc[i-1]), 64'(4));
        end
        $display("contention: grants=%0d failures_so_far=%0d", ng, failures);
        for (int c = 0; c < 6; c++) tick();

        // Reset during the third beat of a 10-beat write.
        req           = 4'b0001;
        req_we        = 4'b0001;
        req_addr      = '0;
        req_addr[15:0] = 16'h0300;
        req_len       = '0;
        req_len[4:0]  = 5'd10;
        for (int c = 1; c <= 4; c++) tick();
        chk("rstmid_beat3_we", 64'(mem_we), 64'(1));
        chk("rstmid_beat3_addr", 64'(mem_addr), 64'(16'h0302));
        reset = 1'b1;
        #1;
        chk("rstmid_mem_we", 64'(mem_we), 64'(0));
        chk("rstmid_gnt", 64'(gnt), 64'(0));
        chk("rstmid_take", 64'(take), 64'(0));
        chk("rstmid_mem_addr", 64'(mem_addr), 64'(0));
        chk("rstmid_mem_wdata", 64'(mem_write_data), 64'(0));
        tick();
        reset           = 1'b0;
        req             = 4'b0100;
        req_we          = 4'b0000;
        req_addr[47:32] = 16'h0400;
        req_len[14:10]  = 5'd2;
        tick();
        chk("post_rst_gnt", 64'(gnt), 64'(4'b0100));
        tick();
        chk("post_rst_mem_addr", 64'(mem_addr), 64'(16'h0400));
        tick();
        chk("post_rst_wait_gnt", 64'(gnt), 64'(4'b0100));
        tick();
        chk("post_rst_last_gnt", 64'(gnt), 64'(0));
        chk("post_rst_done", 64'(done), 64'(4'b0100));
        tick();
        chk("b2b_idle_gnt", 64'(gnt), 64'(0));
        tick();
        chk("b2b_regrant", 64'(gnt), 64'(4'b0100));
        req = '0;
        $display("reset sequence: failures_so_far=%0d", failures);
        for (int c = 0; c < 6; c++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesting hash engines (2..8).
REQ-002 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-003 SHALL have parameter DATA_W, default 32, memory word width.
REQ-004 SHALL have parameter LEN_W, default 5, burst-length field width.
REQ-005 SHALL have port clk  in  1  sole clock; the block uses one clock, rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port req  in  NUM_REQ  per-requester burst request, held until done.
REQ-008 SHALL have port req_we  in  NUM_REQ  per-requester: 1 = write burst, 0 = read burst.
REQ-009 SHALL have port req_addr  in  NUM_REQ*ADDR_W  per-requester burst base address.
REQ-010 SHALL have port req_len  in  NUM_REQ*LEN_W  per-requester beat count.
REQ-011 SHALL have port req_wdata  in  NUM_REQ*DATA_W  per-requester current write word.
REQ-012 SHALL have port gnt  out  NUM_REQ  one-hot grant, held for the whole burst.
REQ-013 SHALL have port take  out  1  beat captured this cycle; the granted writer advances req_wdata on the next edge.
REQ-014 SHALL have port rd_valid  out  NUM_REQ  read word for the indexed requester is valid this cycle.
REQ-015 SHALL have port rd_data  out  DATA_W  shared read data, combinational pass-through of mem_read_data.
REQ-016 SHALL have port done  out  NUM_REQ  one-cycle burst-complete pulse.
REQ-017 SHALL have port mem_clk  out  1  equals clk.
REQ-018 SHALL have ports mem_we/mem_addr/mem_write_data  out  1/ADDR_W/DATA_W  registered memory controls; mem_read_data  in  DATA_W.

Function
REQ-019 SHALL implement states IDLE, BURST, WAIT, LAST.
REQ-020 SHALL, in IDLE with any req high, register gnt by round-robin: search starts at last grantee+1, modulo NUM_REQ; go to BURST.
REQ-021 SHALL latch the grantee's req_we, req_addr, and effective length on the grant edge.
REQ-022 SHALL map effective length as follows: req_len 0 -> 1; values above 16 -> 16.
REQ-023 SHALL, in each BURST cycle, assert take and register mem_addr <= address counter, mem_we <= latched we, mem_write_data <= grantee req_wdata; it SHALL then increment the address and decrement the count.
REQ-024 SHALL wrap the address counter modulo 2^ADDR_W (0xFFFF -> 0x0000).
REQ-025 SHALL move BURST -> WAIT on the edge that issues the last beat; WAIT -> LAST unconditionally; LAST -> IDLE.
REQ-026 SHALL model memory read latency as one cycle: data for mem_addr valid in cycle c appears in cycle c+1; rd_valid[grantee] SHALL be high exactly in those cycles for read bursts and never for writes.
REQ-027 SHALL clear mem_we on the WAIT -> LAST edge and pulse done[grantee] in LAST.
REQ-028 SHALL deassert gnt and take in IDLE/LAST, and deassert take in WAIT.
REQ-029 SHALL give a burst of L beats requested in cycle t: gnt from t+1, mem beats t+2..t+L+1, read data t+3..t+L+2, done at t+L+2, next grant no earlier than t+L+4.
REQ-030 SHALL ignore req, req_we, req_addr, and req_len outside IDLE; a dropped req mid-burst SHALL NOT abort the burst.
REQ-031 SHALL treat a req still high in IDLE after done as a new request, subject to rotation.
REQ-032 SHALL arbitrate simultaneous requests in IDLE per REQ-020 only; a single requester SHALL be re-granted back-to-back.

Reset
REQ-033 SHALL, on reset at any time including mid-burst, immediately set state IDLE, gnt 0, take 0, rd_valid 0, done 0, mem_we 0, mem_addr 0, mem_write_data 0, address/count 0, and round-robin pointer such that requester 0 has highest priority.

Structure
REQ-034 SHALL place the state enum, default widths, and MAX_BURST = 16 in shared package mem_arb_pkg.
REQ-035 SHALL implement the round-robin search as sub-module rr_picker: inputs request vector and last grantee; output one-hot pick; purely combinational.

Verification
REQ-036 The bench SHALL cover a single read: req[1], addr 0x0010, len 3 -> gnt=0010 from t+1; mem_addr 0x10,0x11,0x12 at t+2..t+4; rd_valid[1] t+3..t+5; done[1] at t+5.
REQ-037 The bench SHALL cover a write: req[0], we=1, addr 0x0020, len 2, wdata 0xA,0xB -> mem_we=1 with 0x20/0xA, 0x21/0xB; take twice; mem_we=0 in LAST.
REQ-038 The bench SHALL cover contention: req=1111 held -> grants 0,1,2,3,0 in order, none overlapping.
REQ-039 The bench SHALL cover wrap and clamp: addr 0xFFFE, len 20 -> 16 beats, addresses 0xFFFE,0xFFFF,0x0000..0x000D.
REQ-040 The bench SHALL cover len 0 -> exactly one beat and one done pulse.
REQ-041 The bench SHALL cover reset asserted in the third beat of a 10-beat write -> mem_we 0 and gnt 0 immediately; with req=0100 after release, the next grant goes to requester 2.
